// File: rtl/mips32_imem.sv
// Instruction memory for the single-cycle MIPS32 core.
// Loaded over a valid/ready stream, then served combinationally.
module mips32_imem #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           raddr,
    output logic [DATA_WIDTH-1:0] instr,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic                  reload,
    output logic                  core_run,
    output logic [ADDR_WIDTH:0]   loaded_count,
    output logic                  load_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        ERROR
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   wptr, wptr_n;
    logic [ADDR_WIDTH:0]     count, count_n;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    xfer;
    logic                    in_image;

    assign load_ready   = (state == IDLE) || (state == LOAD);
    assign core_run     = (state == RUN);
    assign load_error   = (state == ERROR);
    assign loaded_count = count;

    // reload wins over a same-cycle transfer
    assign xfer = load_valid & load_ready & ~reload;

    always_comb begin
        state_n = state;
        wptr_n  = wptr;
        count_n = count;
        unique case (state)
            IDLE, LOAD: begin
                if (reload) begin
                    state_n = IDLE;
                    wptr_n  = '0;
                    count_n = '0;
                end else if (xfer) begin
                    wptr_n  = wptr + 1'b1;
                    count_n = count + 1'b1;
                    if (load_last)
                        state_n = RUN;
                    else if (state == LOAD && wptr == LAST_PTR)
                        state_n = ERROR;
                    else
                        state_n = LOAD;
                end
            end
            RUN, ERROR: begin
                if (reload) begin
                    state_n = IDLE;
                    wptr_n  = '0;
                    count_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            wptr  <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            wptr  <= wptr_n;
            count <= count_n;
        end
    end

    // array contents survive reset; validity comes from count
    always_ff @(posedge clock) begin
        if (xfer)
            mem[wptr] <= load_data;
    end

    assign in_image = (raddr < {{(32-ADDR_WIDTH-1){1'b0}}, count});

    always_comb begin
        instr = '0;
        if (state == RUN && in_image)
            instr = mem[raddr[ADDR_WIDTH-1:0]];
    end

endmodule

// File: doc/mips32_imem.md
# mips32_imem

Instruction-memory responder for the single-cycle MIPS32 core: it answers the core's word-address fetch port (`raddr` in, `instr` out) and owns the program-load path that fills memory before execution. A loader pushes words over a valid/ready stream. The block then asserts `core_run`, which the top level uses to enable the core's clock. Until a program is loaded, and for any address outside the loaded image, the block returns NOP (`32'h0`).

## Interface
- `ADDR_WIDTH`, default 6: log2 of memory depth in words (64 words).
- `DATA_WIDTH`, default 32: instruction width.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `reset_n`, input, 1: asynchronous active-low reset.
- `raddr`, input, 32: word address from the core (core drives `pc >> 2`).
- `instr`, output, DATA_WIDTH: instruction at `raddr`; combinational.
- `load_valid`, input, 1: loader has a word on `load_data`.
- `load_data`, input, DATA_WIDTH: instruction word to store.
- `load_last`, input, 1: qualifies the final word of the image.
- `load_ready`, output, 1: block accepts a word this cycle.
- `reload`, input, 1: single-cycle request to discard the image and reload.
- `core_run`, output, 1: image loaded, core may execute.
- `loaded_count`, output, ADDR_WIDTH+1: number of words in the image.
- `load_error`, output, 1: image overflowed memory depth.

## Operation
- Storage: `2**ADDR_WIDTH` × DATA_WIDTH array. Reset does not clear the array. Validity is gated by `loaded_count`.
- States: IDLE, LOAD, RUN, ERROR.
- Reset values: state IDLE, write pointer 0, `loaded_count`=0, `core_run`=0, `load_error`=0. `load_ready`=1 (IDLE). `instr`=0.
- A transfer occurs on a rising edge with `load_valid & load_ready`. The word is written at the write pointer, then the pointer and `loaded_count` increment by 1.
- IDLE: `load_ready`=1.
  - Transfer without `load_last` → LOAD.
  - Transfer with `load_last` → RUN (one-word image).
- LOAD: `load_ready`=1.
  - Transfer with `load_last` → RUN.
  - Transfer without `load_last` when the pointer equals `2**ADDR_WIDTH-1` (memory now full, no last) → ERROR.
- RUN: `load_ready`=0, `core_run`=1, `load_valid` ignored. `reload`=1 → IDLE, pointer and `loaded_count` cleared to 0.
- ERROR: `load_ready`=0, `core_run`=0, `load_error`=1. `reload`=1 → IDLE and clears `load_error`. Otherwise the block stays in ERROR until reset.
- `reload` in IDLE or LOAD: returns to IDLE, clears pointer and count, and drops any transfer in that cycle (reload wins).
- Read path:
  - `instr` = `mem[raddr[ADDR_WIDTH-1:0]]` when state is RUN and `raddr < loaded_count` (full 32-bit compare).
  - Otherwise `instr` = 0. Any `raddr` ≥ depth therefore returns 0.
- `load_last` is ignored unless `load_valid` is high.

## Timing
- Write latency: a word accepted at edge N is readable combinationally after edge N. A RUN entry at edge N makes `core_run` high after edge N.
- Read latency: 0 cycles. `instr` follows `raddr` combinationally within the same cycle, matching the core's single-cycle fetch.
- No read/write overlap: writes happen only in IDLE/LOAD, and reads are gated to 0 outside RUN.
- `load_ready` is a function of state only. It does not depend on `load_valid`, so there is no combinational loop with the loader.
- Reset asserted mid-load: the state returns to IDLE and outputs take their reset values immediately (asynchronous). The partial image is discarded via `loaded_count`=0.
- `loaded_count` maximum is `2**ADDR_WIDTH`, hence the width ADDR_WIDTH+1. A full 64-word image ending with `load_last` on word 64 is legal and enters RUN with count 64.

## Test plan
- Reset, then load 3 words `32'h20010005`, `32'h20020007`, `32'h0000000D` (last on third) → `core_run`=1 after third edge, `loaded_count`=3. `raddr`=0,1,2 return the words; `raddr`=3 returns 0.
- Before any load, sweep `raddr` 0..63 → `instr`=0, `core_run`=0, `load_ready`=1.
- Load 64 words, `load_last` on word 64 → RUN, count 64, `raddr`=63 returns word 64, `raddr`=64 and `32'hFFFFFFFF` return 0.
- Load 64 words without `load_last` → ERROR after edge 64, `load_error`=1, `load_ready`=0. Pulse `reload` → IDLE with errors cleared, then load 1 word with last → RUN, count 1.
- Assert `reset_n`=0 after 2 of 5 words → `loaded_count`=0, `core_run`=0 immediately. Reload 5 words → only the new image is readable.
- In RUN with count 3, hold `load_valid`=1 with new data → memory unchanged, `load_ready`=0. Pulse `reload` with `load_valid`=1 on the same edge → IDLE, count 0, no word written.
